fht_addr_gen_p: RTL and testbench

Parametrised successor of the FHT stage sequencer: for an N-point in-place radix-2 Hartley transform it walks all stages and emits per-cycle read indices for LANES parallel butterfly inputs, the matching write indices delayed by the butterfly pipeline latency, twiddle (coefficient) indices and ping-pong buffer selects. It sits between the start/ready handshake of the FHT top level and the bank-mapping crossbar in front of the sample RAMs.

---
 rtl/fht_addr_gen_p_if.sv | 37 +++
 rtl/fht_addr_gen_p.sv | 203 ++++++++++++++++++++
 tb/tb_fht_addr_gen_p.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fht_addr_gen_p_if.sv
// Bundle between the FHT stage sequencer and its neighbours.
// start        : start pulse from the FHT top level (sampled only while idle)
// rdy          : sequencer idle/done
// addr_rd      : LANES packed read indices, lane k at [k*N_LOG2 +: N_LOG2]
// rd_en        : addr_rd valid
// addr_wr      : LANES packed write indices, same packing
// we           : addr_wr valid
// addr_coef    : twiddle index per butterfly m at [m*(N_LOG2-1) +: N_LOG2-1]
// stage        : current stage
// buf_rd       : ping-pong buffer being read (writes target the other one)
// The master modport is the sequencer side; the slave modport is the consumer side.
interface fht_addr_gen_p_if #(
    parameter int unsigned N_LOG2 = 10,
    parameter int unsigned LANES  = 4
);
    localparam int unsigned SW = $clog2(N_LOG2);

    logic                               start;
    logic                               rdy;
    logic [LANES*N_LOG2-1:0]            addr_rd;
    logic                               rd_en;
    logic [LANES*N_LOG2-1:0]            addr_wr;
    logic                               we;
    logic [(LANES/2)*(N_LOG2-1)-1:0]    addr_coef;
    logic [SW-1:0]                      stage;
    logic                               buf_rd;

    modport master (
        input  start,
        output rdy, addr_rd, rd_en, addr_wr, we, addr_coef, stage, buf_rd
    );

    modport slave (
        output start,
        input  rdy, addr_rd, rd_en, addr_wr, we, addr_coef, stage, buf_rd
    );
endinterface

// File: rtl/fht_addr_gen_p.sv
// FHT stage sequencer: walks all N_LOG2 stages of an in-place radix-2 Hartley
// transform, issuing LANES read indices per cycle, twiddle indices aligned with
// the reads, ping-pong buffer select, and write indices delayed by LAT cycles.
// Ports:
//   iCLK    : clock, rising edge
//   iRESET  : synchronous active-low reset
//   bus     : fht_addr_gen_p_if master modport (start/rdy handshake and all
//             address, enable, stage and buffer outputs)
// Optional build macro FHT_BITREV_EN: stage-0 read indices are bit-reversed so
// natural-order input can be consumed directly; write indices stay natural.
module fht_addr_gen_p #(
    parameter int unsigned N_LOG2 = 10,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LAT    = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    fht_addr_gen_p_if.master  bus
);
    localparam int unsigned N          = 1 << N_LOG2;
    localparam int unsigned HALF_LANES = LANES / 2;
    localparam int unsigned JW         = N_LOG2 - 1;
    localparam int unsigned AW         = LANES * N_LOG2;
    localparam int unsigned CW         = HALF_LANES * JW;
    localparam int unsigned SW         = $clog2(N_LOG2);
    localparam int unsigned T_LAST     = N / LANES - 1;
    localparam int unsigned TW         = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;
    localparam int unsigned DW         = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e          st_q, st_d;
    logic [SW-1:0]   s_q, s_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;

    logic            rdy_q, rd_en_q, buf_q;
    logic [SW-1:0]   stage_q;
    logic [AW-1:0]   rd_nat_q, rd_nat_d;
    logic [CW-1:0]   coef_q, coef_d;

    logic [AW-1:0]   wr_addr_q [LAT];
    logic [LAT-1:0]  wr_v_q;

    // Butterfly number j = t*(LANES/2) + m.
    function automatic logic [JW-1:0] bfly_num(input logic [TW-1:0] t, input int unsigned m);
        return JW'(t) * JW'(HALF_LANES) + JW'(m);
    endfunction

    // Lower input of butterfly j in stage s: j with a zero inserted at bit s.
    function automatic logic [N_LOG2-1:0] lo_idx(input logic [JW-1:0] j, input logic [SW-1:0] s);
        logic [N_LOG2-1:0] jw;
        logic [N_LOG2-1:0] mask;
        jw   = {1'b0, j};
        mask = (N_LOG2'(1) << s) - N_LOG2'(1);
        return ((jw & ~mask) << 1) | (jw & mask);
    endfunction

    // Twiddle index (j mod half) scaled to the N/2-entry table; in the last
    // stage 1<<s wraps to zero in JW bits so the mask becomes all ones.
    function automatic logic [JW-1:0] coef_idx(input logic [JW-1:0] j, input logic [SW-1:0] s);
        logic [JW-1:0] mask;
        mask = (JW'(1) << s) - JW'(1);
        return (j & mask) << (SW'(JW) - s);
    endfunction

    // Sequencer next state
    always_comb begin
        st_d   = st_q;
        s_d    = s_q;
        t_d    = t_q;
        dcnt_d = dcnt_q;
        unique case (st_q)
            StIdle: begin
                if (bus.start) begin
                    st_d = StRead;
                    s_d  = '0;
                    t_d  = '0;
                end
            end
            StRead: begin
                if (t_q == TW'(T_LAST)) begin
                    st_d   = StDrain;
                    dcnt_d = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            StDrain: begin
                if (dcnt_q == DW'(LAT - 1)) begin
                    if (s_q == SW'(N_LOG2 - 1)) begin
                        st_d = StIdle;
                    end else begin
                        st_d = StRead;
                        s_d  = s_q + SW'(1);
                        t_d  = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // Addresses are computed from the next state so the registered outputs
    // line up with the cycle the FSM is in.
    always_comb begin
        rd_nat_d = '0;
        coef_d   = '0;
        for (int unsigned m = 0; m < HALF_LANES; m++) begin
            rd_nat_d[(2*m)*N_LOG2 +: N_LOG2]   = lo_idx(bfly_num(t_d, m), s_d);
            rd_nat_d[(2*m+1)*N_LOG2 +: N_LOG2] = lo_idx(bfly_num(t_d, m), s_d)
                                                 | (N_LOG2'(1) << s_d);
            coef_d[m*JW +: JW]                 = coef_idx(bfly_num(t_d, m), s_d);
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            st_q     <= StIdle;
            s_q      <= '0;
            t_q      <= '0;
            dcnt_q   <= '0;
            rdy_q    <= 1'b1;
            rd_en_q  <= 1'b0;
            rd_nat_q <= '0;
            coef_q   <= '0;
            stage_q  <= '0;
            buf_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            s_q      <= s_d;
            t_q      <= t_d;
            dcnt_q   <= dcnt_d;
            rdy_q    <= (st_d == StIdle);
            rd_en_q  <= (st_d == StRead);
            rd_nat_q <= (st_d == StRead) ? rd_nat_d : '0;
            coef_q   <= (st_d == StRead) ? coef_d : '0;
            stage_q  <= s_d;
            buf_q    <= s_d[0];
        end
    end

    // Write delay line carries natural-order indices
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                wr_addr_q[i] <= '0;
                wr_v_q[i]    <= 1'b0;
            end
        end else begin
            wr_addr_q[0] <= rd_nat_q;
            wr_v_q[0]    <= rd_en_q;
            for (int unsigned i = 1; i < LAT; i++) begin
                wr_addr_q[i] <= wr_addr_q[i-1];
                wr_v_q[i]    <= wr_v_q[i-1];
            end
        end
    end

`ifdef FHT_BITREV_EN
    logic [AW-1:0] rd_out_d, rd_out_q;

    function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        for (int unsigned i = 0; i < N_LOG2; i++) begin
            r[i] = x[N_LOG2-1-i];
        end
        return r;
    endfunction

    always_comb begin
        rd_out_d = rd_nat_d;
        if (s_d == '0) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                rd_out_d[k*N_LOG2 +: N_LOG2] = bit_rev(rd_nat_d[k*N_LOG2 +: N_LOG2]);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            rd_out_q <= '0;
        end else begin
            rd_out_q <= (st_d == StRead) ? rd_out_d : '0;
        end
    end

    assign bus.addr_rd = rd_out_q;
`else
    assign bus.addr_rd = rd_nat_q;
`endif

    assign bus.rdy       = rdy_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.addr_wr   = wr_addr_q[LAT-1];
    assign bus.we        = wr_v_q[LAT-1];
    assign bus.addr_coef = coef_q;
    assign bus.stage     = stage_q;
    assign bus.buf_rd    = buf_q;

endmodule

// File: tb/tb_fht_addr_gen_p.sv
// Bench for fht_addr_gen_p: a small instance (N_LOG2=3, LANES=4, LAT=2) checked
// against hand-computed read/coef/write tables through a scoreboard, plus a
// default-parameter instance checked for cycle count and index coverage.
module tb_fht_addr_gen_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fht_addr_gen_p_if #(.N_LOG2(3), .LANES(4)) s_if ();
    fht_addr_gen_p_if #(.N_LOG2(10), .LANES(4)) b_if ();

    fht_addr_gen_p #(.N_LOG2(3), .LANES(4), .LAT(2)) u_small (
        .iCLK   (clk),
        .iRESET (rst_n),
        .bus    (s_if)
    );

    fht_addr_gen_p #(.N_LOG2(10), .LANES(4), .LAT(4)) u_big (
        .iCLK   (clk),
        .iRESET (rst_n),
        .bus    (b_if)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [3:0]  coef;
        logic [1:0]  stage;
    } rd_exp_t;

    rd_exp_t     rd_q [$];
    logic [11:0] wr_q [$];
    int          wt_q [$];
    rd_exp_t     e;
    logic [1:0]  last_st = 2'd0;
    bit          sb_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event with no expectation pending (t=%0t)", name, $time);
    endtask

    task automatic push_rd(input int a0, a1, a2, a3, c0, c1, st);
        rd_exp_t x;
        x.addr  = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        x.coef  = {2'(c1), 2'(c0)};
        x.stage = 2'(st);
        rd_q.push_back(x);
    endtask

    task automatic push_wr(input int a0, a1, a2, a3);
        wr_q.push_back({3'(a3), 3'(a2), 3'(a1), 3'(a0)});
    endtask

    // Expected response of one full small-instance transform
    task automatic push_run();
`ifdef FHT_BITREV_EN
        push_rd(0, 4, 2, 6, 0, 0, 0);
        push_rd(1, 5, 3, 7, 0, 0, 0);
`else
        push_rd(0, 1, 2, 3, 0, 0, 0);
        push_rd(4, 5, 6, 7, 0, 0, 0);
`endif
        push_rd(0, 2, 1, 3, 0, 2, 1);
        push_rd(4, 6, 5, 7, 0, 2, 1);
        push_rd(0, 4, 1, 5, 0, 1, 2);
        push_rd(2, 6, 3, 7, 2, 3, 2);
        push_wr(0, 1, 2, 3);
        push_wr(4, 5, 6, 7);
        push_wr(0, 2, 1, 3);
        push_wr(4, 6, 5, 7);
        push_wr(0, 4, 1, 5);
        push_wr(2, 6, 3, 7);
    endtask

    // Scoreboard monitor for the small instance
    always @(negedge clk) begin
        if (sb_en) begin
            if (s_if.rd_en) begin
                if (s_if.stage != last_st) check("boundary_pending_wr", 32'(wt_q.size()), 0);
                last_st = s_if.stage;
                if (rd_q.size() == 0) begin
                    fail_now("rd_unexpected");
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr", 32'(s_if.addr_rd), 32'(e.addr));
                    check("rd_coef", 32'(s_if.addr_coef), 32'(e.coef));
                    check("rd_stage", 32'(s_if.stage), 32'(e.stage));
                    check("rd_buf", 32'(s_if.buf_rd), 32'(e.stage[0]));
                end
                wt_q.push_back(cyc);
            end
            if (s_if.we) begin
                if (wr_q.size() == 0) fail_now("wr_unexpected");
                else check("wr_addr", 32'(s_if.addr_wr), 32'(wr_q.pop_front()));
                if (wt_q.size() == 0) fail_now("wr_no_read");
                else check("wr_latency", 32'(cyc - wt_q.pop_front()), 2);
            end
        end
    end

    // Coverage counters for the default-parameter instance
    byte unsigned rd_cnt [10][1024];
    byte unsigned wr_cnt [10][1024];

    always @(negedge clk) begin
        if (b_if.rd_en && b_if.stage < 4'd10) begin
            for (int k = 0; k < 4; k++) rd_cnt[b_if.stage][b_if.addr_rd[k*10 +: 10]]++;
        end
        if (b_if.we && b_if.stage < 4'd10) begin
            for (int k = 0; k < 4; k++) wr_cnt[b_if.stage][b_if.addr_wr[k*10 +: 10]]++;
        end
    end

    // Start the small instance and count busy cycles; optional start pulses
    // while busy, including one on the edge that returns to idle.
    task automatic small_run(input bit inject, output int busy);
        @(negedge clk);
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        check("first_rd_en", 32'(s_if.rd_en), 1);
        busy = 0;
        while (s_if.rdy == 1'b0 && busy < 100) begin
            busy++;
            s_if.start = inject && (busy == 5 || busy == 12);
            @(negedge clk);
        end
        s_if.start = 1'b0;
    endtask

    initial begin
        int  busy;
        bit  seen;
        bit  ok;

        s_if.start = 1'b0;
        b_if.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(s_if.rdy), 1);
        check("rst_rd_en", 32'(s_if.rd_en), 0);
        check("rst_we", 32'(s_if.we), 0);
        check("rst_stage", 32'(s_if.stage), 0);
        check("rst_addr_rd", 32'(s_if.addr_rd), 0);
        check("rst_coef", 32'(s_if.addr_coef), 0);
        rst_n = 1'b1;

        // Run 1: full transform with start pulses while busy
        push_run();
        sb_en = 1'b1;
        small_run(1'b1, busy);
        check("busy_cycles_run1", 32'(busy), 12);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (s_if.rd_en || !s_if.rdy) seen = 1'b1;
        end
        check("start_at_done_ignored", 32'(seen), 0);
        check("rd_all_consumed", 32'(rd_q.size()), 0);
        check("wr_all_consumed", 32'(wr_q.size()), 0);

        // Run 2: reset in the middle of stage 1
        sb_en = 1'b0;
        @(negedge clk);
        s_if.start = 1'b1;
        @(negedge clk);
        s_if.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_stage1_stage", 32'(s_if.stage), 1);
        check("mid_stage1_rd_en", 32'(s_if.rd_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_rdy", 32'(s_if.rdy), 1);
        check("midrst_rd_en", 32'(s_if.rd_en), 0);
        check("midrst_we", 32'(s_if.we), 0);
        check("midrst_stage", 32'(s_if.stage), 0);
        check("midrst_buf", 32'(s_if.buf_rd), 0);
        check("midrst_addr_wr", 32'(s_if.addr_wr), 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (s_if.we) seen = 1'b1;
        end
        check("midrst_flushed", 32'(seen), 0);
        wt_q.delete();

        // Run 3: clean transform after reset
        push_run();
        sb_en = 1'b1;
        small_run(1'b0, busy);
        check("busy_cycles_run3", 32'(busy), 12);
        repeat (3) @(negedge clk);
        check("rd_all_consumed3", 32'(rd_q.size()), 0);
        check("wr_all_consumed3", 32'(wr_q.size()), 0);
        sb_en = 1'b0;

        // Default-parameter instance
        @(negedge clk);
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        busy = 0;
        while (b_if.rdy == 1'b0 && busy < 6000) begin
            busy++;
            @(negedge clk);
        end
        check("big_busy_cycles", 32'(busy), 2600);
        for (int s = 0; s < 10; s++) begin
            ok = 1'b1;
            for (int i = 0; i < 1024; i++) if (rd_cnt[s][i] != 8'd1) ok = 1'b0;
            check($sformatf("big_rd_cover_s%0d", s), 32'(ok), 1);
            ok = 1'b1;
            for (int i = 0; i < 1024; i++) if (wr_cnt[s][i] != 8'd1) ok = 1'b0;
            check($sformatf("big_wr_cover_s%0d", s), 32'(ok), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
